// File: rtl/instr_fetch_unit.sv
// Fetch stage of the accumulator CPU: owns PC and IR, fetches over a req/ack
// handshake, and sequences FETCH -> EXEC -> (FETCH | HALT) once per instruction.
module instr_fetch_unit #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 8,
    parameter int IMM_W   = 4
) (
    input  logic               CLK,
    input  logic               CLB,
    input  logic               LoadIR,
    input  logic               IncPC,
    input  logic               SelPC,
    input  logic               LoadPC,
    input  logic [PC_W-1:0]    RegTarget,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [3:0]         Opcode,
    output logic [IMM_W-1:0]   Imm,
    output logic [PC_W-1:0]    PC,
    output logic               exec_en,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PC_W-1:0]      pc;
    logic [PC_W-1:0]      pc_next;
    logic [INSTR_W-1:0]   ir;
    logic [INSTR_W-1:0]   ir_next;
    logic                 armed;
    logic [PC_W-1:0]      imm_pc;

    // Immediate jump target, zero-extended or truncated to the PC width.
    generate
        if (PC_W > IMM_W) begin : g_imm_ext
            assign imm_pc = {{(PC_W-IMM_W){1'b0}}, ir[IMM_W-1:0]};
        end else begin : g_imm_trunc
            assign imm_pc = ir[PC_W-1:0];
        end
    endgenerate

    // The request stays low for the first cycle after reset so that a stray
    // ack arriving then cannot load the IR.
    assign mem_req  = armed && (state == S_FETCH);
    assign mem_addr = pc;
    assign exec_en  = (state == S_EXEC);
    assign halted   = (state == S_HALT);
    assign Opcode   = ir[INSTR_W-1 -: 4];
    assign Imm      = ir[IMM_W-1:0];
    assign PC       = pc;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value unassigned (no latch).
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;

        case (state)
            S_FETCH: begin
                if (mem_req && mem_ack) begin
                    ir_next    = mem_rdata;
                    state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                // LoadPC outranks IncPC, so the all-ones opcode jumps to Imm.
                if (LoadPC) begin
                    pc_next = SelPC ? imm_pc : RegTarget;
                end else if (IncPC) begin
                    pc_next = pc + 1'b1;
                end
                state_next = LoadIR ? S_FETCH : S_HALT;
            end

            S_HALT: begin
                state_next = S_HALT;
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the values from before this edge, independent of order.
        if (!CLB) begin
            state <= S_FETCH;
            pc    <= '0;
            // NOTE: IR is a single architectural register, not a memory array,
            // so it is reset to the NOP encoding seen by the controller.
            ir    <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            ir    <= ir_next;
            armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a scoreboard queue holds the expected
// IR/PC for each fetch and is checked when the DUT enters EXEC.
module tb_instr_fetch_unit;

    logic       CLK = 1'b0;
    logic       CLB = 1'b0;
    logic       LoadIR = 1'b0, IncPC = 1'b0, SelPC = 1'b0, LoadPC = 1'b0;
    logic [3:0] RegTarget = 4'h0;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic [3:0] Opcode;
    logic [3:0] Imm;
    logic [3:0] PC;
    logic       exec_en;
    logic       halted;

    instr_fetch_unit #(.PC_W(4), .INSTR_W(8), .IMM_W(4)) dut (
        .CLK(CLK), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
        .LoadPC(LoadPC), .RegTarget(RegTarget), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .Opcode(Opcode), .Imm(Imm), .PC(PC), .exec_en(exec_en), .halted(halted)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] imm;
        logic [3:0] pc;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         exec_cnt = 0;
    int         instr_cnt = 0;
    logic [3:0] model_pc = 4'h0;
    logic [3:0] model_op = 4'h0;

    always @(negedge CLK) if (exec_en === 1'b1) exec_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controller outputs outside EXEC are junk that the DUT must ignore.
    task automatic junk_ctrl();
        LoadIR = 1'b1; IncPC = 1'b1; SelPC = 1'b1; LoadPC = 1'b1; RegTarget = 4'hE;
    endtask

    // Release reset with a stray ack in the first cycle; it must not load IR.
    task automatic release_reset();
        @(negedge CLK);
        CLB = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hAB;
        @(posedge CLK); #1;
        mem_ack = 1'b0;
        check("post_reset_ir", Opcode, 4'h0);
        check("post_reset_req", mem_req, 1'b1);
        check("post_reset_exec", exec_en, 1'b0);
        model_pc = 4'h0; model_op = 4'h0;
    endtask

    task automatic run_instr(input logic [7:0] word, input int waits,
                             input logic ld_ir, input logic inc, input logic sel,
                             input logic ld_pc, input logic [3:0] rt);
        exp_t e;
        exp_t got;
        @(negedge CLK);
        for (int w = 0; w <= waits; w++) begin
            check("fetch_req", mem_req, 1'b1);
            check("fetch_addr", mem_addr, model_pc);
            check("fetch_ir_hold", Opcode, model_op);
            if (w < waits) @(negedge CLK);
        end
        mem_ack = 1'b1; mem_rdata = word;
        e.op = word[7:4]; e.imm = word[3:0]; e.pc = model_pc;
        sb.push_back(e);
        @(posedge CLK); #1;
        mem_ack = 1'b0; mem_rdata = ~word;
        @(negedge CLK);
        check("exec_en", exec_en, 1'b1);
        check("exec_req", mem_req, 1'b0);
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check("exec_opcode", Opcode, got.op);
            check("exec_imm", Imm, got.imm);
            check("exec_pc", PC, got.pc);
        end
        model_op = word[7:4];
        LoadIR = ld_ir; IncPC = inc; SelPC = sel; LoadPC = ld_pc; RegTarget = rt;
        if (ld_pc) model_pc = sel ? word[3:0] : rt;
        else if (inc) model_pc = model_pc + 4'h1;
        instr_cnt++;
        @(posedge CLK); #1;
        junk_ctrl();
        check("next_pc", PC, model_pc);
        check("next_halted", halted, !ld_ir);
        check("next_req", mem_req, ld_ir);
        check("next_exec", exec_en, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exec_before;
        junk_ctrl();
        // Reset state.
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_pc", PC, 4'h0);
        check("rst_opcode", Opcode, 4'h0);
        check("rst_imm", Imm, 4'h0);
        check("rst_req", mem_req, 1'b0);
        check("rst_exec", exec_en, 1'b0);
        check("rst_halted", halted, 1'b0);
        release_reset();

        // Sequential program with zero-wait ack.
        run_instr(8'h10, 0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        run_instr(8'h20, 0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        run_instr(8'h00, 0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);

        // Immediate jump, then register jump.
        run_instr(8'h7A, 0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h9);
        run_instr(8'h80, 0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3);

        // Reach 0xF, then wrap to 0 on increment.
        run_instr(8'h7F, 0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
        run_instr(8'h10, 0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);

        // Three wait states: request held four cycles, one exec pulse.
        exec_before = exec_cnt;
        run_instr(8'h35, 3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        check("wait_one_exec", exec_cnt - exec_before, 1);

        // All-ones control: LoadPC wins over IncPC.
        run_instr(8'hF6, 0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h2);

        // Halt: PC and IR frozen, no requests.
        run_instr(8'hF0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        exec_before = exec_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            mem_ack = 1'b1;
            check("halt_req", mem_req, 1'b0);
            check("halt_pc", PC, model_pc);
            check("halt_flag", halted, 1'b1);
            check("halt_ir", Opcode, 4'hF);
        end
        check("halt_no_exec", exec_cnt - exec_before, 0);

        // Reset out of HALT.
        @(negedge CLK);
        CLB = 1'b0; mem_ack = 1'b0;
        @(posedge CLK); #1;
        check("hrst_pc", PC, 4'h0);
        check("hrst_ir", Opcode, 4'h0);
        check("hrst_halted", halted, 1'b0);
        check("hrst_req", mem_req, 1'b0);
        release_reset();
        run_instr(8'h10, 0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);

        // Reset in mid-fetch at PC=5 with an ack on the reset edge.
        run_instr(8'h75, 0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
        @(negedge CLK);
        check("mid_req", mem_req, 1'b1);
        check("mid_addr", mem_addr, 4'h5);
        CLB = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h99;
        @(posedge CLK); #1;
        mem_ack = 1'b0;
        check("mrst_req", mem_req, 1'b0);
        check("mrst_pc", PC, 4'h0);
        check("mrst_ir", Opcode, 4'h0);
        check("mrst_exec", exec_en, 1'b0);
        release_reset();
        run_instr(8'h20, 1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);

        @(negedge CLK);
        check("total_exec", exec_cnt, instr_cnt);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
